// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit/receive state encoding and the default oversampling
// and data-width values, so that uart_sampling_tick, uart_tx_ctrl and the
// receive controller all take them from the same place.
package uart_pkg;

   localparam int DEF_SAMPLE = 32;   // s_tick pulses per bit period
   localparam int DEF_DBIT   = 8;    // data bits per frame

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// Pulls one byte at a time from the TX FIFO and shifts it out on the tx pin
// as start bit, DBIT data bits (LSB first), optional parity bit and
// STOP_BITS stop bits. Each bit lasts SAMPLE pulses of s_tick.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   s_tick       one-cycle oversampling strobe
//   tx_data      byte to send, sampled on the handshake
//   tx_valid     FIFO not empty
//   tx_ready     byte accepted this cycle (FIFO read enable = tx_valid & tx_ready)
//   tx           serial line, idle high
//   tx_busy      frame in progress
//   tx_done_tick one-cycle pulse after the last stop bit completes
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DBIT       = DEF_DBIT,
   parameter int SAMPLE     = DEF_SAMPLE,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic [DBIT-1:0] tx_data,
   input  logic            tx_valid,
   output logic            tx_ready,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   // s_cnt must reach the full stop period, which is the longest phase.
   localparam int CNT_W = $clog2(STOP_BITS * SAMPLE);
   localparam int N_W   = $clog2(DBIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SAMPLE - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * SAMPLE - 1);
   localparam logic [N_W-1:0]   N_LAST    = N_W'(DBIT - 1);

   uart_state_e      state, state_nx;
   logic [CNT_W-1:0] s_cnt, s_cnt_nx;
   logic [N_W-1:0]   n, n_nx;
   logic [DBIT-1:0]  shift, shift_nx;
   logic             par, par_nx;
   logic             tx_nx;
   logic             done_nx;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         s_cnt        <= '0;
         n            <= '0;
         shift        <= '0;
         par          <= 1'b0;
         tx           <= 1'b1;
         tx_done_tick <= 1'b0;
      end else begin
         state        <= state_nx;
         s_cnt        <= s_cnt_nx;
         n            <= n_nx;
         shift        <= shift_nx;
         par          <= par_nx;
         tx           <= tx_nx;
         tx_done_tick <= done_nx;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nx = state;
      s_cnt_nx = s_cnt;
      n_nx     = n;
      shift_nx = shift;
      par_nx   = par;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               shift_nx = tx_data;
               s_cnt_nx = '0;
               n_nx     = '0;
               // Parity is fixed at acceptance, before the shifter destroys the byte.
               par_nx   = (^tx_data) ^ (PARITY_ODD != 0);
               state_nx = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt == BIT_LAST) begin
                  s_cnt_nx = '0;
                  state_nx = DATA;
               end else begin
                  s_cnt_nx = s_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt == BIT_LAST) begin
                  s_cnt_nx = '0;
                  shift_nx = {1'b0, shift[DBIT-1:1]};
                  n_nx     = n + 1'b1;
                  if (n == N_LAST)
                     state_nx = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  s_cnt_nx = s_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_cnt == BIT_LAST) begin
                  s_cnt_nx = '0;
                  state_nx = STOP;
               end else begin
                  s_cnt_nx = s_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt == STOP_LAST) begin
                  s_cnt_nx = '0;
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  s_cnt_nx = s_cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs. The line level is derived from the next state so the tx
   // register switches on the same edge as the state register.
   always_comb begin
      tx_nx = 1'b1;
      unique case (state_nx)
         IDLE:    tx_nx = 1'b1;
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         PARITY:  tx_nx = par_nx;
         STOP:    tx_nx = 1'b1;
         default: tx_nx = 1'b1;
      endcase
      tx_ready = (state == IDLE) && reset_n;
      tx_busy  = (state != IDLE);
   end

endmodule
